// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests and turns EX redirects into flushes and a PC load.
// Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_mem,
  input  logic              ex_branch_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  output logic [5:0]        stall,
  output logic              if_idflush_o,
  output logic              id_exflush_o,
  output logic              pc_redirect_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [5:0]        stall_c;
  logic              accept;
  logic              pc_free;

  // Reset gates the combinational vector so every output reads 0 while rst is low.
  always_comb begin
    stall_c = '0;
    if (rst) begin
      if (stallreq_mem)     stall_c = 6'b011111;
      else if (stallreq_id) stall_c = 6'b000111;
      else if (stallreq_if) stall_c = 6'b000011;
    end
  end

  assign stall   = stall_c;
  assign accept  = rst & ex_branch_i & ~stall_c[3];
  assign pc_free = ~stall_c[0];

  always_comb begin
    if_idflush_o  = 1'b0;
    id_exflush_o  = 1'b0;
    pc_redirect_o = 1'b0;
    pc_target_o   = tgt_q;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if_idflush_o  = accept;
          id_exflush_o  = accept;
          pc_redirect_o = accept & pc_free;
        end
        PEND: begin
          if_idflush_o  = 1'b1;
          id_exflush_o  = 1'b1;
          pc_redirect_o = pc_free;
        end
        default: ;
      endcase
    end
    // A branch accepted in the redirect cycle supersedes any held target.
    if (accept && pc_free) pc_target_o = ex_target_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
    end else begin
      if (accept) tgt_q <= ex_target_i;
      unique case (state_q)
        IDLE:    if (accept && !pc_free) state_q <= PEND;
        PEND:    if (pc_free) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c[0])    stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pc_redirect_o) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected outputs are queued per step and checked before the next edge.
module tb_pipeline_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_if, stallreq_id, stallreq_mem;
  logic              ex_branch_i;
  logic [ADDR_W-1:0] ex_target_i;
  logic [5:0]        stall;
  logic              if_idflush_o, id_exflush_o, pc_redirect_o;
  logic [ADDR_W-1:0] pc_target_o;
  logic [CNT_W-1:0]  stall_cycles_o, flush_count_o;

  typedef struct packed {
    logic [5:0]        stall;
    logic              ifl;
    logic              idl;
    logic              redir;
    logic [ADDR_W-1:0] tgt;
    logic [CNT_W-1:0]  scnt;
    logic [CNT_W-1:0]  fcnt;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned step_n = 0;
  logic [CNT_W-1:0] m_scnt = '0;
  logic [CNT_W-1:0] m_fcnt = '0;

  pipeline_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_mem   (stallreq_mem),
    .ex_branch_i    (ex_branch_i),
    .ex_target_i    (ex_target_i),
    .stall          (stall),
    .if_idflush_o   (if_idflush_o),
    .id_exflush_o   (id_exflush_o),
    .pc_redirect_o  (pc_redirect_o),
    .pc_target_o    (pc_target_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL step%0d %s: got %0h expected %0h", step_n, tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic mem, input logic id, input logic ifq,
                      input logic br, input logic [ADDR_W-1:0] tgt,
                      input logic [5:0] e_stall, input logic e_ifl, input logic e_idl,
                      input logic e_redir, input logic [ADDR_W-1:0] e_tgt);
    exp_t e;
    @(negedge clk);
    rst = r; stallreq_mem = mem; stallreq_id = id; stallreq_if = ifq;
    ex_branch_i = br; ex_target_i = tgt;
    step_n++;
    if (!r) begin
      m_scnt = '0;
      m_fcnt = '0;
    end
`ifdef CTRL_PERF_CNT_EN
    sb.push_back('{e_stall, e_ifl, e_idl, e_redir, e_tgt, m_scnt, m_fcnt});
`else
    sb.push_back('{e_stall, e_ifl, e_idl, e_redir, e_tgt, {CNT_W{1'b0}}, {CNT_W{1'b0}}});
`endif
    if (r) begin
      if (e_stall[0]) m_scnt = m_scnt + 1'b1;
      if (e_redir)    m_fcnt = m_fcnt + 1'b1;
    end
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL step%0d scoreboard: got empty queue expected entry", step_n);
    end else begin
      e = sb.pop_front();
      chk("stall",  {26'd0, stall},         {26'd0, e.stall});
      chk("if_id",  {31'd0, if_idflush_o},  {31'd0, e.ifl});
      chk("id_ex",  {31'd0, id_exflush_o},  {31'd0, e.idl});
      chk("redir",  {31'd0, pc_redirect_o}, {31'd0, e.redir});
      chk("target", pc_target_o,            e.tgt);
      chk("scnt",   {28'd0, stall_cycles_o}, {28'd0, e.scnt});
      chk("fcnt",   {28'd0, flush_count_o},  {28'd0, e.fcnt});
    end
  endtask

  initial begin
    rst = 1'b0; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0;
    ex_branch_i = 1'b0; ex_target_i = '0;
    //   rst mem id if br tgt            stall      ifl idl rdr target
    step(0, 1, 1, 1, 1, 32'h55,    6'b000000, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 0, 32'h0,     6'b011111, 0, 0, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h0,     6'b000111, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h0);
    // immediate redirect
    step(1, 0, 0, 0, 1, 32'h1000,  6'b000000, 1, 1, 1, 32'h1000);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h1000);
    // redirect held while fetch busy
    step(1, 0, 0, 1, 1, 32'h200,   6'b000011, 1, 1, 0, 32'h1000);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 1, 1, 0, 32'h200);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 1, 1, 0, 32'h200);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 1, 1, 1, 32'h200);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 0, 0, 0, 32'h200);
    // MEM stall blocks the branch until it clears
    step(1, 1, 0, 0, 1, 32'h300,   6'b011111, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 1, 32'h300,   6'b011111, 0, 0, 0, 32'h200);
    step(1, 0, 0, 0, 1, 32'h300,   6'b000000, 1, 1, 1, 32'h300);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h300);
    // load-use stall plus branch, then newer branch overwrites pending target
    step(1, 0, 1, 0, 1, 32'h400,   6'b000111, 1, 1, 0, 32'h300);
    step(1, 0, 0, 1, 1, 32'h500,   6'b000011, 1, 1, 0, 32'h400);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 1, 1, 1, 32'h500);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h500);
    // new branch arriving in the exit cycle of PEND
    step(1, 0, 0, 1, 1, 32'h600,   6'b000011, 1, 1, 0, 32'h500);
    step(1, 0, 0, 0, 1, 32'h700,   6'b000000, 1, 1, 1, 32'h700);
    // reset while pending
    step(1, 0, 0, 1, 1, 32'h800,   6'b000011, 1, 1, 0, 32'h700);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 1, 1, 0, 32'h800);
    step(0, 0, 0, 1, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 0, 32'h0,     6'b000011, 0, 0, 0, 32'h0);
    // long fetch stall to exercise counter wrap
    for (int i = 0; i < 17; i++)
      step(1, 0, 0, 1, 0, 32'h0,   6'b000011, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 1, 32'h900,   6'b000000, 1, 1, 1, 32'h900);
    step(1, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 0, 0, 32'h900);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
